// File: rtl/ddr_req_arbiter_pkg.sv
// rtl/ddr_req_arbiter_pkg.sv - shared constants and types for the DDR2 request arbiter
// Purpose: command codes, DDR2 user-interface field widths, FSM state encoding and
//          a helper for index widths, shared by ddr_req_arbiter and ddr_tag_fifo.
package ddr_req_arbiter_pkg;

  localparam int CMD_W  = 3;
  localparam int ADDR_W = 31;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;

  localparam logic [CMD_W-1:0] CMD_WRITE = 3'b000;
  localparam logic [CMD_W-1:0] CMD_READ  = 3'b001;

  typedef enum logic {
    IDLE   = 1'b0,
    WBEAT1 = 1'b1
  } arb_state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_tag_fifo.sv
// rtl/ddr_tag_fifo.sv - read-owner tag FIFO for the DDR2 request arbiter
// Purpose: remembers which requester owns each outstanding read, in issue order.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push_i, din_i   write a tag (ignored while full)
//   pop_i           drop the head tag (ignored while empty)
//   dout_o          head tag
//   full_o, empty_o occupancy flags
module ddr_tag_fifo
  import ddr_req_arbiter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// rtl/ddr_req_arbiter.sv - round-robin arbiter of N requesters onto one DDR2 user interface
// Purpose: grants one command at a time into the address FIFO (writes carry two
//          data beats), tags reads with their owner and routes 2-beat read returns
//          back to the owner in issue order.
// Ports:
//   clk, rst                                   clock, asynchronous active-high reset
//   req_valid/cmd/addr/wdf_din/wdf_mask        per-requester command inputs
//   req_grant, req_wdf_take                    per-requester command / beat acknowledges
//   af_full, af_cmd_din, af_addr_din, af_wr_en address FIFO side
//   wdf_full, wdf_din, wdf_mask_din, wdf_wr_en write-data FIFO side
//   rdf_valid, rdf_rd_en                       read-data FIFO side
//   rd_valid, rd_en                            per-requester read return handshake
module ddr_req_arbiter
  import ddr_req_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [CMD_W*N_REQ-1:0]    req_cmd,
  input  logic [ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [DATA_W*N_REQ-1:0]   req_wdf_din,
  input  logic [MASK_W*N_REQ-1:0]   req_wdf_mask,
  output logic [N_REQ-1:0]          req_grant,
  output logic [N_REQ-1:0]          req_wdf_take,
  input  logic                      af_full,
  input  logic                      wdf_full,
  output logic [CMD_W-1:0]          af_cmd_din,
  output logic [ADDR_W-1:0]         af_addr_din,
  output logic                      af_wr_en,
  output logic [DATA_W-1:0]         wdf_din,
  output logic [MASK_W-1:0]         wdf_mask_din,
  output logic                      wdf_wr_en,
  input  logic                      rdf_valid,
  output logic                      rdf_rd_en,
  output logic [N_REQ-1:0]          rd_valid,
  input  logic [N_REQ-1:0]          rd_en
);

  localparam int IW = idx_width(N_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  last_grant_q, last_grant_d;
  logic [IW-1:0]  owner_q, owner_d;       // writer whose beat 1 is pending
  logic           beat_q, beat_d;         // read-return beat within the burst

  logic [CMD_W-1:0]  cmd_a  [N_REQ];
  logic [ADDR_W-1:0] addr_a [N_REQ];
  logic [DATA_W-1:0] din_a  [N_REQ];
  logic [MASK_W-1:0] mask_a [N_REQ];

  logic          cand_found;
  logic [IW-1:0] cand_idx;
  logic          tag_push, tag_pop, tag_full, tag_empty;
  logic [IW-1:0] tag_head;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign cmd_a[g]  = req_cmd[CMD_W*g +: CMD_W];
    assign addr_a[g] = req_addr[ADDR_W*g +: ADDR_W];
    assign din_a[g]  = req_wdf_din[DATA_W*g +: DATA_W];
    assign mask_a[g] = req_wdf_mask[MASK_W*g +: MASK_W];
  end

  // First valid requester at or after last_grant+1. A blocked candidate stays
  // the candidate because last_grant only moves on a grant.
  always_comb begin : cand_search
    int j;
    j          = 0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last_grant_q) + k) % N_REQ;
      if (!cand_found && req_valid[j]) begin
        cand_found = 1'b1;
        cand_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    req_grant    = '0;
    req_wdf_take = '0;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    tag_push     = 1'b0;
    af_cmd_din   = cmd_a[cand_idx];
    af_addr_din  = addr_a[cand_idx];
    wdf_din      = (state_q == WBEAT1) ? din_a[owner_q]  : din_a[cand_idx];
    wdf_mask_din = (state_q == WBEAT1) ? mask_a[owner_q] : mask_a[cand_idx];

    case (state_q)
      IDLE: begin
        if (cand_found && !af_full) begin
          if (cmd_a[cand_idx] == CMD_WRITE) begin
            if (!wdf_full) begin
              af_wr_en               = 1'b1;
              wdf_wr_en              = 1'b1;
              req_grant[cand_idx]    = 1'b1;
              req_wdf_take[cand_idx] = 1'b1;
              last_grant_d           = cand_idx;
              owner_d                = cand_idx;
              state_d                = WBEAT1;
            end
          end else if (!tag_full) begin
            // Every non-write code is issued as a read.
            af_wr_en            = 1'b1;
            req_grant[cand_idx] = 1'b1;
            tag_push            = 1'b1;
            last_grant_d        = cand_idx;
          end
        end
      end
      WBEAT1: begin
        if (!wdf_full) begin
          wdf_wr_en             = 1'b1;
          req_wdf_take[owner_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read return runs independently of command issue.
    rd_valid  = '0;
    rdf_rd_en = 1'b0;
    if (!tag_empty) begin
      rd_valid[tag_head] = rdf_valid;
      rdf_rd_en          = rdf_valid && rd_en[tag_head];
    end
    tag_pop = rdf_rd_en && beat_q;
    beat_d  = beat_q ^ rdf_rd_en;

    // Outputs are quiet for the whole time reset is held, not just after the edge.
    if (rst) begin
      req_grant    = '0;
      req_wdf_take = '0;
      af_wr_en     = 1'b0;
      wdf_wr_en    = 1'b0;
      tag_push     = 1'b0;
      tag_pop      = 1'b0;
      rd_valid     = '0;
      rdf_rd_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_IDX;
      owner_q      <= '0;
      beat_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      beat_q       <= beat_d;
    end
  end

  ddr_tag_fifo #(
    .WIDTH (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_push),
    .din_i   (cand_idx),
    .pop_i   (tag_pop),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb/tb_ddr_req_arbiter.sv - self-checking bench for ddr_req_arbiter
module tb_ddr_req_arbiter;

  localparam int N  = 4;
  localparam int TD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [3*N-1:0]   req_cmd;
  logic [31*N-1:0]  req_addr;
  logic [128*N-1:0] req_wdf_din;
  logic [16*N-1:0]  req_wdf_mask;
  logic [N-1:0]     req_grant, req_wdf_take;
  logic             af_full, wdf_full;
  logic [2:0]       af_cmd_din;
  logic [30:0]      af_addr_din;
  logic             af_wr_en;
  logic [127:0]     wdf_din;
  logic [15:0]      wdf_mask_din;
  logic             wdf_wr_en;
  logic             rdf_valid, rdf_rd_en;
  logic [N-1:0]     rd_valid, rd_en;

  always #5 clk = ~clk;

  ddr_req_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdf_din(req_wdf_din), .req_wdf_mask(req_wdf_mask),
    .req_grant(req_grant), .req_wdf_take(req_wdf_take),
    .af_full(af_full), .wdf_full(wdf_full),
    .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
    .rdf_valid(rdf_valid), .rdf_rd_en(rdf_rd_en),
    .rd_valid(rd_valid), .rd_en(rd_en)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit auto_drop = 1'b0;

  // Reference model: queue of read owners, pending write owner, rotation point.
  int m_last = N - 1;
  int m_pend = -1;
  int m_beat = 0;
  int tags[$];

  logic [N-1:0] e_grant, e_take, e_rdv;
  logic         e_af, e_wdf, e_rdf;
  logic [2:0]   e_cmd;
  logic [30:0]  e_addr;
  logic [127:0] e_din;
  logic [15:0]  e_mask;

  int grant_log[$];
  int rdv_log[$];
  int take2_log[$];
  int n_wdf_push = 0;
  int n_rdf_pop  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_eval();
    int sz, c, push_c;
    logic [2:0] cmd;
    e_grant = '0; e_take = '0; e_rdv = '0;
    e_af = 1'b0; e_wdf = 1'b0; e_rdf = 1'b0;
    e_cmd = '0; e_addr = '0; e_din = '0; e_mask = '0;
    if (rst) begin
      m_last = N - 1; m_pend = -1; m_beat = 0; tags.delete();
      return;
    end
    sz = tags.size();
    push_c = -1;
    if (m_pend >= 0) begin
      if (!wdf_full) begin
        e_wdf = 1'b1; e_take[m_pend] = 1'b1;
        e_din = req_wdf_din[128*m_pend +: 128];
        e_mask = req_wdf_mask[16*m_pend +: 16];
        m_pend = -1;
      end
    end else begin
      c = -1;
      for (int k = 1; k <= N; k++)
        if (c < 0 && req_valid[(m_last + k) % N]) c = (m_last + k) % N;
      if (c >= 0 && !af_full) begin
        cmd = req_cmd[3*c +: 3];
        if (cmd == 3'b000) begin
          if (!wdf_full) begin
            e_af = 1'b1; e_wdf = 1'b1; e_grant[c] = 1'b1; e_take[c] = 1'b1;
            e_cmd = cmd; e_addr = req_addr[31*c +: 31];
            e_din = req_wdf_din[128*c +: 128];
            e_mask = req_wdf_mask[16*c +: 16];
            m_pend = c; m_last = c;
          end
        end else if (sz < TD) begin
          e_af = 1'b1; e_grant[c] = 1'b1;
          e_cmd = cmd; e_addr = req_addr[31*c +: 31];
          push_c = c; m_last = c;
        end
      end
    end
    if (sz > 0) begin
      e_rdv[tags[0]] = rdf_valid;
      e_rdf = rdf_valid && rd_en[tags[0]];
    end
    if (e_rdf) begin
      if (m_beat == 1) void'(tags.pop_front());
      m_beat ^= 1;
    end
    if (push_c >= 0) tags.push_back(push_c);
  endtask

  task automatic step();
    logic [N-1:0] drop;
    @(negedge clk);
    model_eval();
    check_eq("req_grant", 128'(req_grant), 128'(e_grant));
    check_eq("req_wdf_take", 128'(req_wdf_take), 128'(e_take));
    check_eq("af_wr_en", 128'(af_wr_en), 128'(e_af));
    check_eq("wdf_wr_en", 128'(wdf_wr_en), 128'(e_wdf));
    check_eq("rd_valid", 128'(rd_valid), 128'(e_rdv));
    check_eq("rdf_rd_en", 128'(rdf_rd_en), 128'(e_rdf));
    if (e_af) begin
      check_eq("af_cmd_din", 128'(af_cmd_din), 128'(e_cmd));
      check_eq("af_addr_din", 128'(af_addr_din), 128'(e_addr));
    end
    if (e_wdf) begin
      check_eq("wdf_din", wdf_din, e_din);
      check_eq("wdf_mask_din", 128'(wdf_mask_din), 128'(e_mask));
    end
    if (req_grant != '0) grant_log.push_back(oh_idx(req_grant));
    if (rdf_rd_en) begin
      rdv_log.push_back(oh_idx(rd_valid));
      n_rdf_pop++;
    end
    if (req_wdf_take[2]) take2_log.push_back(cyc);
    if (wdf_wr_en) n_wdf_push++;
    drop = auto_drop ? e_grant : '0;
    cyc++;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~drop;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rdf_valid = 1'b0; rd_en = '0;
    af_full = 1'b0; wdf_full = 1'b0;
    step();
    rst = 1'b0;
    grant_log.delete(); rdv_log.delete();
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_addr[31*i +: 31] = 31'($urandom);
    for (int w = 0; w < 4*N; w++) req_wdf_din[32*w +: 32] = $urandom;
    req_wdf_mask = {$urandom, $urandom};
  endtask

  initial begin
    int c0;
    int exp_rd[8];
    rst = 1'b1; req_valid = '0; req_cmd = '0; req_addr = '0;
    req_wdf_din = '0; req_wdf_mask = '0; af_full = 1'b0; wdf_full = 1'b0;
    rdf_valid = 1'b0; rd_en = '0;

    // Reset state.
    step();
    step();
    rst = 1'b0;

    // Four reads at 0x100*i, then two beats each routed back in order.
    for (int i = 0; i < N; i++) begin
      req_cmd[3*i +: 3] = 3'b001;
      req_addr[31*i +: 31] = 31'(32'h100 * i);
    end
    req_valid = '1; auto_drop = 1'b1;
    steps(6);
    check_eq("rd4_grant_count", 128'(grant_log.size()), 128'(4));
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check_eq("rd4_grant_order", 128'(grant_log[i]), 128'(i));
    rdf_valid = 1'b1; rd_en = '1;
    steps(8);
    rdf_valid = 1'b0;
    exp_rd = '{0, 0, 1, 1, 2, 2, 3, 3};
    check_eq("rd4_beat_count", 128'(rdv_log.size()), 128'(8));
    for (int i = 0; i < rdv_log.size() && i < 8; i++)
      check_eq("rd4_beat_owner", 128'(rdv_log[i]), 128'(exp_rd[i]));

    // Write from requester 2 stalled in beat 1 by wdf_full for 5 cycles.
    randomize_data();
    req_cmd[6 +: 3] = 3'b000;
    n_wdf_push = 0; take2_log.delete();
    c0 = cyc;
    req_valid = 4'b0100;
    step();
    wdf_full = 1'b1;
    steps(5);
    wdf_full = 1'b0;
    steps(2);
    check_eq("wr_push_count", 128'(n_wdf_push), 128'(2));
    check_eq("wr_take_count", 128'(take2_log.size()), 128'(2));
    if (take2_log.size() == 2)
      check_eq("wr_take2_cycle", 128'(take2_log[1] - c0), 128'(6));

    // All requesters valid: strict rotation.
    do_reset();
    for (int i = 0; i < N; i++) req_cmd[3*i +: 3] = 3'b001;
    auto_drop = 1'b0; req_valid = '1;
    steps(5);
    req_valid = '0;
    exp_rd[0:4] = '{0, 1, 2, 3, 0};
    check_eq("rr_grant_count", 128'(grant_log.size()), 128'(5));
    for (int i = 0; i < grant_log.size() && i < 5; i++)
      check_eq("rr_grant_order", 128'(grant_log[i]), 128'(exp_rd[i]));
    rdf_valid = 1'b1; rd_en = '1;
    steps(10);
    rdf_valid = 1'b0;

    // Nine reads, tag FIFO fills at eight until a 2-beat return pops one.
    do_reset();
    req_cmd[0 +: 3] = 3'b001; req_valid = 4'b0001;
    steps(12);
    check_eq("full_grant_count", 128'(grant_log.size()), 128'(8));
    rdf_valid = 1'b1; rd_en = 4'b0001;
    steps(2);
    rdf_valid = 1'b0;
    check_eq("full_held_during_pop", 128'(grant_log.size()), 128'(8));
    step();
    check_eq("full_ninth_grant", 128'(grant_log.size()), 128'(9));
    req_valid = '0;

    // Non-head rd_en is ignored.
    do_reset();
    req_cmd[3 +: 3] = 3'b001; req_valid = 4'b0010; auto_drop = 1'b1;
    steps(2);
    n_rdf_pop = 0;
    rdf_valid = 1'b1; rd_en = 4'b1000;
    steps(3);
    check_eq("nonhead_no_pop", 128'(n_rdf_pop), 128'(0));
    check_eq("nonhead_rd_valid", 128'(rd_valid), 128'(4'b0010));
    rd_en = 4'b0010;
    steps(2);
    rdf_valid = 1'b0;
    check_eq("head_pops", 128'(n_rdf_pop), 128'(2));
    step();
    check_eq("head_drained", 128'(rd_valid), 128'(0));

    // Reset during beat 1 of a write.
    do_reset();
    randomize_data();
    req_cmd[9 +: 3] = 3'b000; req_valid = 4'b1000;
    step();
    wdf_full = 1'b1;
    step();
    for (int i = 0; i < N; i++) req_cmd[3*i +: 3] = 3'b001;
    req_valid = '1; wdf_full = 1'b0; rst = 1'b1;
    #1;
    check_eq("rst_wdf_wr_en", 128'(wdf_wr_en), 128'(0));
    check_eq("rst_take", 128'(req_wdf_take), 128'(0));
    check_eq("rst_grant", 128'(req_grant), 128'(0));
    check_eq("rst_af_wr_en", 128'(af_wr_en), 128'(0));
    step();
    rst = 1'b0; grant_log.delete();
    step();
    check_eq("post_rst_first_grant_count", 128'(grant_log.size()), 128'(1));
    if (grant_log.size() > 0)
      check_eq("post_rst_first_grant", 128'(grant_log[0]), 128'(0));
    auto_drop = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 2000; it++) begin
      int r;
      randomize_data();
      for (int i = 0; i < N; i++) begin
        r = int'($urandom_range(0, 9));
        req_cmd[3*i +: 3] = (r < 4) ? 3'b000 : (r < 8) ? 3'b001 : 3'(2 + (r % 6));
      end
      req_valid = N'($urandom);
      rd_en     = N'($urandom);
      af_full   = ($urandom_range(0, 3) == 0);
      wdf_full  = ($urandom_range(0, 3) == 0);
      rdf_valid = ($urandom_range(0, 1) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
